// File: rtl/rbus_xbar_nxm.sv
// Packet-atomic NxM rbus crossbar: per-input FIFO, header-dest routing, round-robin per output.
// Header written at t leaves at t+2 uncontended; i_rdy drops once a whole packet no longer fits.
module rbus_xbar_nxm #(
  parameter int N        = 5,
  parameter int M        = 3,
  parameter int DW       = 72,
  parameter int DEPTH    = 32,
  parameter int PKT_MAX  = 15,
  parameter int DEST_LSB = 64,
  parameter int LEN_LSB  = 60,
  parameter int PRIO_BIT = 71
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_stb,
  input  logic [N-1:0]    i_sof,
  input  logic [N*DW-1:0] i_data,
  output logic [2*N-1:0]  i_rdy,
  output logic [2*N-1:0]  i_rdyE,
  output logic [M-1:0]    o_stb,
  output logic [M-1:0]    o_sof,
  output logic [M*DW-1:0] o_data,
  input  logic [2*M-1:0]  o_rdy,
  input  logic [2*M-1:0]  o_rdyE,
  output logic            ff_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_XFER} state_t;

  logic [DW:0]   r_mem [N][DEPTH];
  logic [AW-1:0] r_wp [N];
  logic [AW-1:0] r_rp [N];
  logic [CW-1:0] r_cnt [N];
  logic [N-1:0]  r_rdy;
  logic [4:0]    r_drop [N];
  state_t        r_st [M];
  logic [IW-1:0] r_gnt [M];
  logic [IW-1:0] r_ptr [M];
  logic [4:0]    r_rem [M];

  logic [N-1:0]  w_ne, w_hsof, w_hlane, w_busy, w_push, w_pop, w_bad, w_stray;
  logic [DW-1:0] w_hdat [N];
  logic [3:0]    w_hdest [N];
  logic [3:0]    w_hlen [N];
  logic [CW-1:0] w_cnt_nx [N];
  logic [N-1:0]  w_cand [M];
  logic [M-1:0]  w_gv, w_send, w_last;
  logic [IW-1:0] w_gidx [M];
  logic          w_unused;

  assign w_unused = ^o_rdyE;

  always_comb begin
    w_busy = '0;
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++)
        if (r_st[m] == S_XFER && int'(r_gnt[m]) == n) w_busy[n] = 1'b1;
  end

  // A head that is not owned by an output and not being dropped must be a valid header.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      w_ne[n]                 = (r_cnt[n] != '0);
      {w_hsof[n], w_hdat[n]}  = r_mem[n][r_rp[n]];
      w_hdest[n]              = w_hdat[n][DEST_LSB +: 4];
      w_hlen[n]               = w_hdat[n][LEN_LSB +: 4];
      w_hlane[n]              = w_hdat[n][PRIO_BIT];
      w_push[n]               = i_stb[n] && (int'(r_cnt[n]) != DEPTH);
      w_stray[n] = w_ne[n] && !w_busy[n] && (r_drop[n] == 5'd0) && !w_hsof[n];
      w_bad[n]   = w_ne[n] && !w_busy[n] && (r_drop[n] == 5'd0) && w_hsof[n] &&
                   (int'(w_hdest[n]) >= M);
      i_rdy[2*n +: 2]  = {2{r_rdy[n]}};
      i_rdyE[2*n +: 2] = {2{!w_ne[n]}};
    end
  end

  always_comb begin
    int c;
    c = 0;
    for (int m = 0; m < M; m++) begin
      w_send[m] = (r_st[m] == S_XFER) && w_ne[r_gnt[m]];
      w_last[m] = w_send[m] && (r_rem[m] == 5'd1);
      w_cand[m] = '0;
      w_gv[m]   = 1'b0;
      w_gidx[m] = '0;
      for (int n = 0; n < N; n++)
        w_cand[m][n] = w_ne[n] && w_hsof[n] && !w_busy[n] && (r_drop[n] == 5'd0) &&
                       (int'(w_hdest[n]) == m) && o_rdy[2*m + int'(w_hlane[n])];
      for (int k = 0; k < N; k++) begin
        c = (int'(r_ptr[m]) + k) % N;
        if (!w_gv[m] && w_cand[m][c]) begin
          w_gv[m]   = 1'b1;
          w_gidx[m] = IW'(c);
        end
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int n = 0; n < N; n++)
      w_pop[n] = w_stray[n] || ((r_drop[n] != 5'd0) && w_ne[n]);
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++)
        if (w_send[m] && int'(r_gnt[m]) == n) w_pop[n] = 1'b1;
    for (int n = 0; n < N; n++)
      w_cnt_nx[n] = r_cnt[n] + CW'(w_push[n]) - CW'(w_pop[n]);
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < N; n++)
      if (w_push[n]) r_mem[n][r_wp[n]] <= {i_sof[n], i_data[n*DW +: DW]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < N; n++) begin
        r_wp[n]   <= '0;
        r_rp[n]   <= '0;
        r_cnt[n]  <= '0;
        r_drop[n] <= '0;
      end
      r_rdy  <= '0;
      ff_err <= 1'b0;
    end else begin
      for (int n = 0; n < N; n++) begin
        if (w_push[n]) r_wp[n] <= r_wp[n] + AW'(1);
        if (w_pop[n])  r_rp[n] <= r_rp[n] + AW'(1);
        r_cnt[n] <= w_cnt_nx[n];
        r_rdy[n] <= (DEPTH - int'(w_cnt_nx[n])) >= (PKT_MAX + 1);
        if (w_bad[n])                             r_drop[n] <= 5'(w_hlen[n]) + 5'd1;
        else if (r_drop[n] != 5'd0 && w_ne[n])    r_drop[n] <= r_drop[n] - 5'd1;
      end
      if (|w_bad || |w_stray || |(i_stb & ~w_push)) ff_err <= 1'b1;
    end
  end

  // The grant for the next packet lands in the same cycle the last word pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < M; m++) begin
        r_st[m]  <= S_IDLE;
        r_gnt[m] <= '0;
        r_ptr[m] <= '0;
        r_rem[m] <= '0;
      end
      o_stb  <= '0;
      o_sof  <= '0;
      o_data <= '0;
    end else begin
      for (int m = 0; m < M; m++) begin
        if (w_send[m]) begin
          o_stb[m]            <= 1'b1;
          o_sof[m]            <= w_hsof[r_gnt[m]];
          o_data[m*DW +: DW]  <= w_hdat[r_gnt[m]];
          r_rem[m]            <= r_rem[m] - 5'd1;
        end else begin
          o_stb[m]            <= 1'b0;
          o_sof[m]            <= 1'b0;
          o_data[m*DW +: DW]  <= '0;
        end
        if (r_st[m] == S_IDLE || w_last[m]) begin
          if (w_gv[m]) begin
            r_st[m]  <= S_XFER;
            r_gnt[m] <= w_gidx[m];
            r_ptr[m] <= (int'(w_gidx[m]) == N - 1) ? '0 : w_gidx[m] + IW'(1);
            r_rem[m] <= 5'(w_hlen[w_gidx[m]]) + 5'd1;
          end else begin
            r_st[m]  <= S_IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rbus_xbar_nxm.sv
// Directed bench for rbus_xbar_nxm: routing, round-robin, lanes, flow control, errors, reset.
module tb_rbus_xbar_nxm;
  localparam int N = 5, M = 3, DW = 72;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_stb, i_sof;
  logic [N*DW-1:0] i_data;
  logic [2*N-1:0]  i_rdy, i_rdyE;
  logic [M-1:0]    o_stb, o_sof;
  logic [M*DW-1:0] o_data;
  logic [2*M-1:0]  o_rdy, o_rdyE;
  logic            ff_err;

  int n_vec = 0;
  int n_bad = 0;

  rbus_xbar_nxm dut (
    .clk(clk), .rst(rst),
    .i_stb(i_stb), .i_sof(i_sof), .i_data(i_data), .i_rdy(i_rdy), .i_rdyE(i_rdyE),
    .o_stb(o_stb), .o_sof(o_sof), .o_data(o_data), .o_rdy(o_rdy), .o_rdyE(o_rdyE),
    .ff_err(ff_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input int d, input int len, input bit lane, input int tag);
    logic [DW-1:0] w;
    w        = '0;
    w[71]    = lane;
    w[67:64] = d[3:0];
    w[63:60] = len[3:0];
    w[31:0]  = tag;
    return w;
  endfunction

  function automatic logic [DW-1:0] pay(input int tag);
    logic [DW-1:0] w;
    w       = '0;
    w[40]   = 1'b1;
    w[31:0] = tag;
    return w;
  endfunction

  function automatic logic [DW-1:0] pw(input logic [DW-1:0] h, input int base, input int k);
    return (k == 0) ? h : pay(base + k);
  endfunction

  function automatic logic [DW-1:0] od(input int m);
    return o_data[m*DW +: DW];
  endfunction

  task automatic put(input int n, input bit sof, input logic [DW-1:0] d);
    i_stb[n]          = 1'b1;
    i_sof[n]          = sof;
    i_data[n*DW +: DW] = d;
  endtask

  task automatic idle_in();
    i_stb  = '0;
    i_sof  = '0;
    i_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [M-1:0] e_stb;
  logic         seen;
  logic [31:0]  rr_exp [6];

  initial begin
    rst = 1'b0;
    idle_in();
    o_rdy  = '1;
    o_rdyE = '1;
    rr_exp = '{32'h200, 32'h210, 32'h240, 32'h201, 32'h211, 32'h241};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stb",  80'(o_stb), 80'(0));
    chk("rst_sof",  80'(o_sof), 80'(0));
    chk("rst_data", 80'(od(0) | od(1) | od(2)), 80'(0));
    chk("rst_err",  80'(ff_err), 80'(0));
    chk("rst_rdyE", 80'(i_rdyE), 80'(10'h3FF));
    rst = 1'b1;
    tick();
    chk("rel_rdy",  80'(i_rdy), 80'(10'h3FF));

    // uncontended: input 2 -> output 1, len 3
    for (int k = 0; k < 7; k++) begin
      if (k < 4) put(2, k == 0, pw(hdr(1, 3, 0, 'h100), 'h100, k)); else idle_in();
      tick();
      e_stb = (k >= 2 && k <= 5) ? 3'b010 : 3'b000;
      chk("u_stb", 80'(o_stb), 80'(e_stb));
      if (k >= 2 && k <= 5) begin
        chk("u_dat", 80'(od(1)), 80'(pw(hdr(1, 3, 0, 'h100), 'h100, k - 2)));
        chk("u_sof", 80'(o_sof), 80'((k == 2) ? 3'b010 : 3'b000));
      end
    end
    chk("u_err", 80'(ff_err), 80'(0));

    // round robin: inputs 0,1,4 each two len-0 packets to output 0
    for (int p = 0; p < 2; p++) begin
      put(0, 1, hdr(0, 0, 0, 'h200 + p));
      put(1, 1, hdr(0, 0, 0, 'h210 + p));
      put(4, 1, hdr(0, 0, 0, 'h240 + p));
      tick();
    end
    idle_in();
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("rr_stb", 80'(o_stb), 80'(3'b001));
      chk("rr_dat", 80'(od(0)), 80'(hdr(0, 0, 0, int'(rr_exp[j]))));
    end
    tick();
    chk("rr_end", 80'(o_stb), 80'(0));

    // parallel: 0 -> 0 and 1 -> 2, len 15 each
    for (int k = 0; k < 20; k++) begin
      if (k < 16) begin
        put(0, k == 0, pw(hdr(0, 15, 0, 'h300), 'h300, k));
        put(1, k == 0, pw(hdr(2, 15, 0, 'h400), 'h400, k));
      end else idle_in();
      tick();
      e_stb = (k >= 2 && k <= 17) ? 3'b101 : 3'b000;
      chk("par_stb", 80'(o_stb), 80'(e_stb));
      if (k >= 2 && k <= 17) begin
        chk("par_d0", 80'(od(0)), 80'(pw(hdr(0, 15, 0, 'h300), 'h300, k - 2)));
        chk("par_d2", 80'(od(2)), 80'(pw(hdr(2, 15, 0, 'h400), 'h400, k - 2)));
      end
    end

    // lane-1 packet waits while output 2 lane 1 is not ready
    o_rdy[5:4] = 2'b01;
    put(1, 1, hdr(2, 1, 1, 'h500));
    tick();
    put(1, 0, pay('h501));
    tick();
    idle_in();
    seen = 1'b0;
    repeat (6) begin tick(); seen |= o_stb[2]; end
    chk("bp_hold", 80'(seen), 80'(0));
    o_rdy[5:4] = 2'b11;
    tick();
    chk("bp_gnt", 80'(o_stb), 80'(0));
    tick();
    chk("bp_hdr_stb", 80'(o_stb), 80'(3'b100));
    chk("bp_hdr", 80'(od(2)), 80'(hdr(2, 1, 1, 'h500)));
    tick();
    chk("bp_pay", 80'(od(2)), 80'(pay('h501)));
    tick();
    chk("bp_end", 80'(o_stb), 80'(0));

    // flow control on input 3 with output 0 blocked
    o_rdy[1:0] = 2'b00;
    chk("fc_e0", 80'(i_rdyE[7:6]), 80'(2'b11));
    for (int k = 0; k < 17; k++) begin
      if (k < 16) put(3, k == 0, pw(hdr(0, 15, 0, 'h600), 'h600, k));
      else        put(3, 1, hdr(0, 0, 0, 'h610));
      tick();
      if (k == 15) chk("fc_rdy16", 80'(i_rdy[7:6]), 80'(2'b11));
      if (k == 16) begin
        chk("fc_rdy17", 80'(i_rdy[7:6]), 80'(2'b00));
        chk("fc_e17",   80'(i_rdyE[7:6]), 80'(2'b00));
      end
    end
    idle_in();
    o_rdy[1:0] = 2'b11;
    tick();
    chk("fc_still", 80'(i_rdy[7:6]), 80'(2'b00));
    tick();
    chk("fc_back", 80'(i_rdy[7:6]), 80'(2'b11));
    repeat (15) tick();
    chk("fc_last",  80'(od(0)), 80'(pay('h60F)));
    chk("fc_e1",    80'(i_rdyE[7:6]), 80'(2'b00));
    tick();
    chk("fc_gap",   80'(o_stb), 80'(0));
    tick();
    chk("fc_h2",    80'(od(0)), 80'(hdr(0, 0, 0, 'h610)));
    chk("fc_empty", 80'(i_rdyE[7:6]), 80'(2'b11));

    // bad destination
    chk("err_pre", 80'(ff_err), 80'(0));
    put(2, 1, hdr(5, 2, 0, 'h700));
    tick();
    put(2, 0, pay('h701));
    tick();
    put(2, 0, pay('h702));
    tick();
    idle_in();
    seen = 1'b0;
    repeat (6) begin tick(); seen |= |o_stb; end
    chk("bad_quiet", 80'(seen), 80'(0));
    chk("bad_err",   80'(ff_err), 80'(1));
    chk("bad_empty", 80'(i_rdyE[5:4]), 80'(2'b11));
    repeat (3) tick();
    chk("err_sticky", 80'(ff_err), 80'(1));

    // reset during word 5 of a len-15 transfer
    for (int k = 0; k < 8; k++) begin
      put(0, k == 0, pw(hdr(0, 15, 0, 'h800), 'h800, k));
      tick();
    end
    chk("mid_word5", 80'(od(0)), 80'(pay('h805)));
    idle_in();
    rst = 1'b0;
    #1;
    chk("mid_stb", 80'(o_stb), 80'(0));
    chk("mid_err", 80'(ff_err), 80'(0));
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mid_rdy",  80'(i_rdy), 80'(10'h3FF));
    chk("mid_rdyE", 80'(i_rdyE), 80'(10'h3FF));
    chk("mid_quiet", 80'(o_stb), 80'(0));
    put(4, 1, hdr(2, 0, 1, 'h900));
    tick();
    idle_in();
    tick();
    chk("new_wait", 80'(o_stb), 80'(0));
    tick();
    chk("new_stb", 80'(o_stb), 80'(3'b100));
    chk("new_dat", 80'(od(2)), 80'(hdr(2, 0, 1, 'h900)));
    chk("new_sof", 80'(o_sof), 80'(3'b100));

    // stray payload word at an idle head
    put(2, 0, pay('hA00));
    tick();
    idle_in();
    seen = 1'b0;
    repeat (3) begin tick(); seen |= |o_stb; end
    chk("stray_quiet", 80'(seen), 80'(0));
    chk("stray_err",   80'(ff_err), 80'(1));
    chk("stray_empty", 80'(i_rdyE[5:4]), 80'(2'b11));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
